// File: rtl/md_scheduler_pkg.sv
// Shared MD op/state encodings and op classification helpers.
// Pure declarations; no latency, no flow control.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic is_md_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// E/D-stage handshake and HI/LO result bundle between the pipeline and the MD unit.
// Pipeline side drives the master modport; the scheduler uses the slave modport.
interface md_scheduler_if;
  logic        E_md_valid;
  logic [2:0]  E_md_op;
  logic [31:0] E_rs_fw;
  logic [31:0] E_rt_fw;
  logic        D_md_use;
  logic        md_busy;
  logic        md_stall;
  logic [31:0] E_md_rd;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_md_valid, E_md_op, E_rs_fw, E_rt_fw, D_md_use,
    input  md_busy, md_stall, E_md_rd, HI, LO
  );

  modport slave (
    input  E_md_valid, E_md_op, E_rs_fw, E_rt_fw, D_md_use,
    output md_busy, md_stall, E_md_rd, HI, LO
  );
endinterface

// File: rtl/md_scheduler_arith.sv
// Combinational mult/div datapath: {hi, lo} result plus divide-by-zero flag.
// Zero latency; no flow control (the scheduler samples it on a start edge).
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [63:0] o_res,
  output logic        o_div_zero
);

  logic        w_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;

  // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  always_comb begin
    w_signed   = (i_op == MD_MULT) || (i_op == MD_DIV);
    w_neg_a    = w_signed & i_rs[31];
    w_neg_b    = w_signed & i_rt[31];
    w_ext_a    = {{32{w_neg_a}}, i_rs};
    w_ext_b    = {{32{w_neg_b}}, i_rt};
    w_prod     = w_ext_a * w_ext_b;
    w_mag_a    = w_neg_a ? (32'd0 - i_rs) : i_rs;
    w_mag_b    = w_neg_b ? (32'd0 - i_rt) : i_rt;
    o_div_zero = (i_rt == 32'd0);
    w_div_b    = o_div_zero ? 32'd1 : w_mag_b;
    w_uq       = w_mag_a / w_div_b;
    w_ur       = w_mag_a % w_div_b;
    w_q        = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    w_r        = w_neg_a ? (32'd0 - w_ur) : w_ur;
    o_res      = is_md_mul(i_op) ? w_prod : {w_r, w_q};
  end

endmodule

// File: rtl/md_scheduler.sv
// Multi-cycle mult/div sequencer owning HI/LO; a start commits MUL_CYCLES/DIV_CYCLES edges later.
// Backpressure: md_stall holds any MD op in D while busy or while a start sits in E.
module md_scheduler
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_scheduler_if.slave  md
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e        r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [63:0]      r_shadow, w_shadow;
  logic             r_dbz, w_dbz;
  logic [31:0]      r_hi, w_hi;
  logic [31:0]      r_lo, w_lo;

  logic [63:0]      w_res;
  logic             w_div_zero;
  logic             w_start;

  md_arith u_arith (
    .i_op       (md.E_md_op),
    .i_rs       (md.E_rs_fw),
    .i_rt       (md.E_rt_fw),
    .o_res      (w_res),
    .o_div_zero (w_div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_shadow <= w_shadow;
      r_dbz    <= w_dbz;
      r_hi     <= w_hi;
      r_lo     <= w_lo;
    end
  end

  assign w_start = md.E_md_valid & is_md_start(md.E_md_op);

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_shadow = r_shadow;
    w_dbz    = r_dbz;
    w_hi     = r_hi;
    w_lo     = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_shadow = w_res;
          if (is_md_mul(md.E_md_op)) begin
            w_state = ST_MUL;
            w_cnt   = CNT_W'(MUL_CYCLES);
            w_dbz   = 1'b0;
          end else begin
            w_state = ST_DIV;
            w_cnt   = CNT_W'(DIV_CYCLES);
            w_dbz   = w_div_zero;
          end
        end else if (md.E_md_valid && md.E_md_op == MD_MTHI) begin
          w_hi = md.E_rs_fw;
        end else if (md.E_md_valid && md.E_md_op == MD_MTLO) begin
          w_lo = md.E_rs_fw;
        end
      end
      // E-stage ops arriving while busy are ignored; the stall rule should prevent them.
      ST_MUL, ST_DIV: begin
        w_cnt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state = ST_IDLE;
          if (!r_dbz) begin
            w_hi = r_shadow[63:32];
            w_lo = r_shadow[31:0];
          end
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  assign md.md_busy  = (r_state != ST_IDLE);
  assign md.md_stall = reset & md.D_md_use & (md.md_busy | w_start);
  assign md.E_md_rd  = (md.E_md_op == MD_MFHI) ? r_hi :
                       (md.E_md_op == MD_MFLO) ? r_lo : 32'd0;
  assign md.HI       = r_hi;
  assign md.LO       = r_lo;

endmodule
